gf180mcu_osu_sc_12t_cell_bist2: RTL and testbench
=================================================

# gf180mcu_osu_sc_12T_cell_bist2

Built-in self-test sequencer for a single 2-input standard cell of the 12T library, such as and2, or2 or nand2. It drives every input combination onto the external cell, waits a programmable settle time, and samples the cell output. It compares each sample against a parameterised truth table and accumulates a pass/fail result. It sits beside the cell-under-test in characterization and silicon-monitor wrappers; the cell itself is instantiated outside this block.

## Interface
Parameters:
- TRUTH, 4'b1000 (and2): expected Y per vector index v={A,B}; bit v is the expected output.
- SETTLE_CYCLES, 2: cycles each vector is held before sampling; legal range is 1..255.
- ITERS, 1: full passes over the 4 vectors per run; legal range is 1..255.
- CNT_W, 3: width of the error counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  begin a run; sampled only in IDLE.
- A_O  output  1  drive to cell input A (registered).
- B_O  output  1  drive to cell input B (registered).
- Y_I  input  1  output of cell-under-test.
- BUSY  output  1  run in progress.
- DONE  output  1  one-cycle pulse at end of run.
- PASS  output  1  last run had zero mismatches; held until next START.
- ERRCNT  output  CNT_W  saturating mismatch count of last/current run.
- FAIL_VEC  output  4  sticky per-vector failure flags; bit v set if vector v ever mismatched.

## Operation
- Reset values: A_O=0, B_O=0, BUSY=0, DONE=0, PASS=0, ERRCNT=0, FAIL_VEC=0, state IDLE, v=0, iteration=0.
- IDLE, START=1:
  - ERRCNT, FAIL_VEC and PASS cleared.
  - v=0 and {A_O,B_O}=2'b00.
  - Settle counter loaded with SETTLE_CYCLES; go SETTLE.
- SETTLE: hold A_O/B_O; decrement the counter. SETTLE occupies exactly SETTLE_CYCLES cycles, then go SAMPLE.
- SAMPLE (one cycle): compare Y_I with TRUTH[v]. X/Z on Y_I counts as a mismatch in simulation (case inequality).
  - On mismatch:
    - ERRCNT increments, saturating at all-ones.
    - FAIL_VEC[v] set.
  - If v<3: v++, drive the new vector, reload the counter, go SETTLE.
  - Else if iteration<ITERS-1: iteration++, v=0, drive 2'b00, go SETTLE.
  - Else go DONE.
- DONE (one cycle):
  - DONE=1 and PASS<=(no mismatch in run).
  - A_O/B_O return to 0; go IDLE.
- BUSY=1 in SETTLE, SAMPLE and DONE.
- START is ignored outside IDLE.
- Results (PASS, ERRCNT, FAIL_VEC) persist in IDLE until the next accepted START or RST.
- PASS is computed from an internal any-mismatch flag, not from ERRCNT, so saturation cannot mask a failure.

## Timing
- START sampled at edge k → BUSY=1 and vector 0 on A_O/B_O from cycle k+1.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES cycles of SETTLE, then 1 cycle of SAMPLE.
- Y_I is sampled at the end of each SAMPLE cycle, SETTLE_CYCLES+1 edges after the vector change.
- DONE is high during cycle k+1+4·ITERS·(SETTLE_CYCLES+1). Defaults: k+13. BUSY drops the cycle after DONE.
- START held high continuously: a new run is accepted in the IDLE cycle following DONE, giving 1 idle cycle between runs.
- RST has priority over every other event in any state. Outputs take reset values the following cycle; no partial result is retained.
- The vector order is fixed at 00, 01, 10, 11, i.e. B_O toggles fastest.

## Structure
- Package gf180mcu_osu_sc_12T_bist_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - truth-table constants TT_AND2=4'b1000, TT_OR2=4'b1110, TT_NAND2=4'b0111, TT_NOR2=4'b0001, TT_XOR2=4'b0110, TT_XNOR2=4'b1001.
- One sub-module, gf180mcu_osu_sc_12T_bist_timer: an 8-bit loadable down-counter with load, enable and expire outputs, used for the settle interval.
- Iteration and vector counters live in the top-level module.

## Test plan
- and2 cell connected, defaults, START at k → A_O/B_O step 00,01,10,11 every 3 cycles; DONE at k+13; PASS=1, ERRCNT=0, FAIL_VEC=0.
- Y_I stuck-at-0, TRUTH=TT_AND2 → ERRCNT=1, FAIL_VEC=4'b1000, PASS=0.
- ITERS=8, CNT_W=3, Y_I stuck-at-1, TRUTH=TT_AND2 → 24 mismatches; ERRCNT saturates at 7, FAIL_VEC=4'b0111, PASS=0, DONE at k+1+96.
- START pulsed while BUSY → ignored, DONE timing unchanged. START held high → second run begins at DONE+1; results cleared at that edge.
- RST asserted during SETTLE of vector 2 → next cycle all outputs at reset values, BUSY=0. A following START runs a full clean sequence with PASS=1.
- SETTLE_CYCLES=1 with a cell model delayed by 2 cycles → mismatches flagged. Same model with SETTLE_CYCLES=2 → PASS=1.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12T_bist_pkg.sv
// gf180mcu_osu_sc_12T_bist_pkg: sequencer states and 2-input cell truth tables
package gf180mcu_osu_sc_12T_bist_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;
endpackage

// File: rtl/gf180mcu_osu_sc_12T_bist_timer.sv
// gf180mcu_osu_sc_12T_bist_timer: 8-bit loadable down-counter for the settle interval
module gf180mcu_osu_sc_12T_bist_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] value,
  output logic       expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && cnt != 8'd0) cnt <= cnt - 8'd1;
  assign expire = en && cnt == 8'd1;
endmodule

// File: rtl/gf180mcu_osu_sc_12t_cell_bist2.sv
// gf180mcu_osu_sc_12t_cell_bist2: exhaustive self-test sequencer for one 2-input cell
module gf180mcu_osu_sc_12t_cell_bist2
  import gf180mcu_osu_sc_12T_bist_pkg::*;
#(
  parameter logic [3:0] TRUTH         = TT_AND2,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         ITERS         = 1,
  parameter int         CNT_W         = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             A_O,
  output logic             B_O,
  input  logic             Y_I,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERRCNT,
  output logic [3:0]       FAIL_VEC
);
  state_t     state;
  logic [1:0] v;
  logic [7:0] iter;
  logic       any_err;
  logic       expire;
  // timer reloads whenever not settling, so it always enters SETTLE full
  gf180mcu_osu_sc_12T_bist_timer u_timer (
    .clk(CLK), .rst(RST), .load(state != S_SETTLE), .en(state == S_SETTLE),
    .value(8'(SETTLE_CYCLES)), .expire(expire)
  );
  assign {A_O, B_O} = v;
  assign BUSY = state != S_IDLE;
  assign DONE = state == S_DONE;
  always_ff @(posedge CLK)
    if (RST) begin
      state    <= S_IDLE;
      v        <= '0;
      iter     <= '0;
      any_err  <= 1'b0;
      PASS     <= 1'b0;
      ERRCNT   <= '0;
      FAIL_VEC <= '0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          ERRCNT   <= '0;
          FAIL_VEC <= '0;
          PASS     <= 1'b0;
          any_err  <= 1'b0;
          v        <= '0;
          iter     <= '0;
          state    <= S_SETTLE;
        end
        S_SETTLE: if (expire) state <= S_SAMPLE;
        S_SAMPLE: begin
          if (Y_I !== TRUTH[v]) begin
            ERRCNT      <= ERRCNT == {CNT_W{1'b1}} ? ERRCNT : ERRCNT + 1'b1;
            FAIL_VEC[v] <= 1'b1;
            any_err     <= 1'b1;
          end
          if (v != 2'd3) begin
            v     <= v + 2'd1;
            state <= S_SETTLE;
          end else if (iter != 8'(ITERS - 1)) begin
            iter  <= iter + 8'd1;
            v     <= '0;
            state <= S_SETTLE;
          end else state <= S_DONE;
        end
        S_DONE: begin
          PASS  <= ~any_err;
          v     <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_cell_bist2.sv
// tb_gf180mcu_osu_sc_12t_cell_bist2: three sequencer configurations against a run-level timing model
module tb_gf180mcu_osu_sc_12t_cell_bist2;
  import gf180mcu_osu_sc_12T_bist_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] start, rst, busy_w, done_w, pass_w, a_w, b_w, y_w;
  logic [2:0][2:0] err_w;
  logic [2:0][3:0] fv_w;
  int mode [3];
  int checks = 0;
  int passed = 0;
  bit armed = 1'b0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  // inst0: defaults, inst1: ITERS=8, inst2: SETTLE_CYCLES=1
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int S = (g == 2) ? 1 : 2;
    localparam int I = (g == 1) ? 8 : 1;
    localparam int N = 4 * I * (S + 1);
    localparam logic [3:0] TT = TT_AND2;
    logic d1 = 1'b0, d2 = 1'b0, rnd = 1'b0;
    always @(posedge clk) begin
      d1 <= a_w[g] & b_w[g];
      d2 <= d1;
    end
    always @(negedge clk) rnd <= 1'($urandom);
    // cell modes: 0 and2, 1 stuck-0, 2 stuck-1, 3 random, 4 and2 delayed 2 cycles
    assign y_w[g] = mode[g] == 0 ? (a_w[g] & b_w[g]) : mode[g] == 1 ? 1'b0 :
                    mode[g] == 2 ? 1'b1 : mode[g] == 3 ? rnd : d2;

    gf180mcu_osu_sc_12t_cell_bist2 #(
      .TRUTH(TT_AND2), .SETTLE_CYCLES(S), .ITERS(I), .CNT_W(3)
    ) dut (
      .CLK(clk), .RST(rst[g]), .START(start[g]), .A_O(a_w[g]), .B_O(b_w[g]),
      .Y_I(y_w[g]), .BUSY(busy_w[g]), .DONE(done_w[g]), .PASS(pass_w[g]),
      .ERRCNT(err_w[g]), .FAIL_VEC(fv_w[g])
    );

    // t = cycle number within the run (1 = first busy cycle), DONE at t = N+1
    bit run_m = 1'b0;
    int t = 0;
    int e_err = 0;
    int vec;
    logic [3:0] e_fail = '0;
    bit e_any = 1'b0, e_pass = 1'b0;
    always @(posedge clk) begin
      if (rst[g]) begin
        run_m = 0; t = 0; e_err = 0; e_fail = '0; e_any = 0; e_pass = 0;
      end else if (!run_m) begin
        if (start[g]) begin
          run_m = 1; t = 1; e_err = 0; e_fail = '0; e_any = 0; e_pass = 0;
        end
      end else begin
        if (t <= N && (t - 1) % (S + 1) == S) begin
          vec = ((t - 1) / (S + 1)) % 4;
          if (y_w[g] !== TT[vec]) begin
            e_err = e_err < 7 ? e_err + 1 : 7;
            e_fail[vec] = 1'b1;
            e_any = 1;
          end
        end
        if (t == N + 1) begin
          run_m = 0;
          e_pass = !e_any;
        end else t++;
      end
    end

    bit dn;
    int ev;
    always @(negedge clk) if (armed) begin
      dn = run_m && t == N + 1;
      ev = run_m ? ((t - 1) / (S + 1)) % 4 : 0;
      chk($sformatf("i%0d busy", g), busy_w[g], run_m);
      chk($sformatf("i%0d done", g), done_w[g], dn);
      if (!dn) begin
        chk($sformatf("i%0d vector t=%0d", g, t), {a_w[g], b_w[g]}, ev);
        chk($sformatf("i%0d pass", g), pass_w[g], e_pass);
      end
      chk($sformatf("i%0d errcnt", g), err_w[g], e_err);
      chk($sformatf("i%0d fail_vec", g), fv_w[g], e_fail);
    end
  end

  task automatic wait_done(input int g, input int poke, output int lat);
    lat = 1;
    start[g] = (poke == 1);
    while (!done_w[g] && lat < 2000) begin
      @(negedge clk);
      lat++;
      start[g] = (lat == poke);
    end
    start[g] = 1'b0;
  endtask

  task automatic run(input int g, input int poke, output int lat);
    start[g] = 1'b1;
    @(negedge clk);
    wait_done(g, poke, lat);
  endtask

  initial begin
    int lat, n;
    rst = '1;
    start = '0;
    mode = '{0, 0, 0};
    repeat (2) @(negedge clk);
    armed = 1'b1;
    @(negedge clk);
    rst = '0;
    chk("reset busy", busy_w[0], 0);
    chk("reset errcnt", err_w[1], 0);
    run(0, 0, lat);
    chk("and2 done latency", lat, 13);
    @(negedge clk);
    chk("and2 pass", pass_w[0], 1);
    chk("and2 fail_vec", fv_w[0], 0);
    mode[0] = 1;
    run(0, 0, lat);
    @(negedge clk);
    chk("stuck0 errcnt", err_w[0], 1);
    chk("stuck0 fail_vec", fv_w[0], 4'b1000);
    chk("stuck0 pass", pass_w[0], 0);
    mode[1] = 2;
    run(1, 0, lat);
    chk("iters8 done latency", lat, 97);
    @(negedge clk);
    chk("stuck1 errcnt saturated", err_w[1], 7);
    chk("stuck1 fail_vec", fv_w[1], 4'b0111);
    chk("stuck1 pass", pass_w[1], 0);
    mode[0] = 0;
    run(0, 5, lat);
    chk("start while busy latency", lat, 13);
    mode[0] = 1;
    start[0] = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!done_w[0] && lat < 2000) begin @(negedge clk); lat++; end
    @(negedge clk);
    chk("held start idle gap", busy_w[0], 0);
    chk("held start first result", err_w[0], 1);
    @(negedge clk);
    start[0] = 1'b0;
    chk("held start rerun busy", busy_w[0], 1);
    chk("held start results cleared", err_w[0], 0);
    wait_done(0, 0, lat);
    chk("held start second latency", lat, 13);
    @(negedge clk);
    mode[0] = 2;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (!(a_w[0] && !b_w[0]) && n < 100) begin @(negedge clk); n++; end
    chk("reached vector 2", n < 100, 1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("mid-run reset busy", busy_w[0], 0);
    chk("mid-run reset errcnt", err_w[0], 0);
    chk("mid-run reset a_o", a_w[0], 0);
    mode[0] = 0;
    run(0, 0, lat);
    @(negedge clk);
    chk("after reset pass", pass_w[0], 1);
    mode[2] = 4;
    run(2, 0, lat);
    chk("settle1 latency", lat, 9);
    @(negedge clk);
    chk("delayed cell settle1 pass", pass_w[2], 0);
    chk("delayed cell settle1 fail_vec", fv_w[2], 4'b1000);
    mode[0] = 4;
    run(0, 0, lat);
    @(negedge clk);
    chk("delayed cell settle2 pass", pass_w[0], 1);
    repeat (1500) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        start[g] = ($urandom % 4) == 0;
        rst[g] = ($urandom % 150) == 0;
        if ($urandom % 40 == 0) mode[g] = $urandom % 5;
      end
    end
    start = '0;
    rst = '0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
